// File: rtl/sar_search_controller.sv
// ---------------------------------------------------------------------------
// sar_search_controller
//
// Successive-approximation search controller. It drives the B operand of a
// magnitude comparator (probe) and reads back the comparator's
// greater/equal/less flags. From these it binary-searches the unknown A
// operand, MSB first, and reports the value it finds on result.
//
// Parameters:
//   WIDTH        operand width of probe and result (>= 2)
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   start        pulse; begins a search when idle
//   abort        terminates a search in progress (no done pulse)
//   cmp_greater  comparator flag, A >  probe
//   cmp_equal    comparator flag, A == probe
//   cmp_less     comparator flag, A <  probe
//   probe        registered value driven to comparator B (0 when idle)
//   busy         high while searching
//   done         one-cycle pulse at search end
//   err          flag protocol violation seen; valid with done
//   result       discovered A; valid when done=1 and err=0; held until the
//                next search completes
//
// Build option:
//   SAR_FLAG_REG_EN  when defined, the comparator flags are registered before
//                    they are evaluated. Each bit then takes two cycles:
//                    SEARCH drives the probe and captures the flags, and
//                    SAMPLE evaluates the captured flags.
// ---------------------------------------------------------------------------
module sar_search_controller #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             cmp_greater,
    input  logic             cmp_equal,
    input  logic             cmp_less,
    output logic [WIDTH-1:0] probe,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MSB      = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_STEP = {{(IDX_W-1){1'b0}}, 1'b1};

    // SAMPLE is reached only when the flags are registered.
    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        SAMPLE
    } state_t;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] acc_q,    acc_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic [WIDTH-1:0] probe_q,  probe_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic             err_q,    err_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [2:0]       flags_live;
    logic [2:0]       eval_flags;
    logic             eval_en;
    logic [WIDTH-1:0] next_bit;

    assign flags_live = {cmp_greater, cmp_equal, cmp_less};

    // Bit tested on the following step. It is only used while idx_q > 0, so
    // the wrap of idx_q - 1 at idx_q = 0 never reaches the probe.
    assign next_bit = ONE << (idx_q - IDX_STEP);

`ifdef SAR_FLAG_REG_EN
    logic [2:0] flag_q;

    // The flags are captured every cycle. The value held during SAMPLE is
    // the one taken at the end of the SEARCH cycle for the current probe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_q <= 3'b000;
        end else begin
            flag_q <= flags_live;
        end
    end

    assign eval_flags = flag_q;
    assign eval_en    = (state_q == SAMPLE) && !abort;
`else
    assign eval_flags = flags_live;
    assign eval_en    = (state_q == SEARCH) && !abort;
`endif

    always_comb begin
        logic finish;
        // NOTE: every next-state variable gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d  = state_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        probe_d  = probe_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        result_d = result_q;
        finish   = 1'b0;

        case (state_q)
            IDLE: begin
                // start is ignored in the done cycle and when it comes
                // together with abort.
                if (start && !abort && !done_q) begin
                    state_d = SEARCH;
                    acc_d   = '0;
                    idx_d   = IDX_TOP;
                    probe_d = MSB;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                end
            end
            SEARCH: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    probe_d = '0;
                end
`ifdef SAR_FLAG_REG_EN
                else begin
                    state_d = SAMPLE;
                end
`endif
            end
`ifdef SAR_FLAG_REG_EN
            SAMPLE: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    probe_d = '0;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        // The flags are evaluated against the current probe. abort has
        // already removed this cycle from evaluation.
        if (eval_en) begin
            if (!$onehot(eval_flags) || (eval_flags[2] && idx_q == '0)) begin
                // The flags are not exactly one-hot, or "greater" was
                // reported on the last bit, which cannot happen when the
                // comparator works correctly.
                err_d    = 1'b1;
                result_d = probe_q;
                finish   = 1'b1;
            end else if (eval_flags[1]) begin
                result_d = probe_q;
                finish   = 1'b1;
            end else if (eval_flags[2]) begin
                // Keep the tested bit and try the next lower one.
                acc_d   = probe_q;
                idx_d   = idx_q - IDX_STEP;
                probe_d = probe_q | next_bit;
                state_d = SEARCH;
            end else if (idx_q == '0) begin
                result_d = acc_q;
                finish   = 1'b1;
            end else begin
                // Drop the tested bit and try the next lower one.
                idx_d   = idx_q - IDX_STEP;
                probe_d = acc_q | next_bit;
                state_d = SEARCH;
            end
        end

        if (finish) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            probe_d = '0;
            done_d  = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values its inputs had before this clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            idx_q    <= IDX_TOP;
            probe_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            probe_q  <= probe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            result_q <= result_d;
        end
    end

    assign probe  = probe_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;

endmodule

// File: tb/tb_sar_search_controller.sv
// ---------------------------------------------------------------------------
// tb_sar_search_controller
//
// Directed bench for sar_search_controller with WIDTH = 4. An ideal 4-bit
// comparator is modelled here against a_val. It can be overridden with
// forced flag patterns so that protocol errors can be injected. Expected
// probe sequences, latencies and results are worked out by hand from the
// binary-search rules.
// ---------------------------------------------------------------------------
module tb_sar_search_controller;

    localparam int WIDTH = 4;
`ifdef SAR_FLAG_REG_EN
    localparam int CYC = 2;
`else
    localparam int CYC = 1;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic             cmp_greater;
    logic             cmp_equal;
    logic             cmp_less;
    logic [WIDTH-1:0] probe;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] result;

    logic [WIDTH-1:0] a_val;
    logic             force_en;
    logic [2:0]       force_flags;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Comparator model: an ideal comparator against a_val, or forced flags.
    assign {cmp_greater, cmp_equal, cmp_less} = force_en ? force_flags :
        {a_val > probe, a_val == probe, a_val < probe};

    sar_search_controller #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .cmp_greater (cmp_greater),
        .cmp_equal   (cmp_equal),
        .cmp_less    (cmp_less),
        .probe       (probe),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .result      (result)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one search and records what the DUT does. Distinct probe values
    // are packed MSB-first into pseq, one nibble per probe. cycles counts the
    // cycles from the start edge until done is seen. The task returns in the
    // done cycle.
    task automatic do_search(input logic [3:0] a, input logic fe,
                             input logic [2:0] ff, output int cycles,
                             output logic [31:0] pseq, output logic [3:0] res,
                             output logic e, output logic b, output logic tmo);
        logic [3:0] last;
        if (done) step();
        a_val       = a;
        force_en    = fe;
        force_flags = ff;
        start = 1'b1;
        step();
        start  = 1'b0;
        cycles = 0;
        pseq   = '0;
        last   = 4'h0;
        tmo    = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                tmo = 1'b0;
                break;
            end
            if (probe !== last) begin
                pseq = {pseq[27:0], probe};
                last = probe;
            end
            cycles++;
            step();
        end
        res = result;
        e   = err;
        b   = busy;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        a_val = 4'h0;
        force_en    = 1'b0;
        force_flags = 3'b000;
        step();
        step();
        checks++;
        if ({probe, busy, done, err, result} !== 11'b0) begin
            failures++;
            $display("FAIL reset_outputs: probe=%0d busy=%0b done=%0b err=%0b result=%0d expected all zero",
                     probe, busy, done, err, result);
        end
        rst = 1'b0;
        step();
    endtask

    // Checks latency, probe sequence, result, err and busy for one search.
    task automatic test_search(input string name, input logic [3:0] a,
                               input logic fe, input logic [2:0] ff,
                               input int exp_cyc, input logic [31:0] exp_seq,
                               input logic [3:0] exp_res, input logic exp_err);
        int         cyc;
        logic [31:0] seq;
        logic [3:0] res;
        logic       e, b, tmo;
        do_search(a, fe, ff, cyc, seq, res, e, b, tmo);
        checks++;
        if (tmo) begin
            failures++;
            $display("FAIL %s_timeout: no done within 40 cycles", name);
        end
        checks++;
        if (cyc !== exp_cyc) begin
            failures++;
            $display("FAIL %s_latency: got %0d cycles expected %0d", name, cyc, exp_cyc);
        end
        checks++;
        if (seq !== exp_seq) begin
            failures++;
            $display("FAIL %s_probes: got %h expected %h", name, seq, exp_seq);
        end
        checks++;
        if (res !== exp_res || e !== exp_err) begin
            failures++;
            $display("FAIL %s_result: got result=%0d err=%0b expected result=%0d err=%0b",
                     name, res, e, exp_res, exp_err);
        end
        checks++;
        if (b !== 1'b0 || probe !== 4'h0) begin
            failures++;
            $display("FAIL %s_idle_at_done: got busy=%0b probe=%0d expected busy=0 probe=0",
                     name, b, probe);
        end
    endtask

    task automatic test_done_pulse();
        // Continues straight from the A=10 search, in its done cycle.
        step();
        checks++;
        if (done !== 1'b0 || result !== 4'd10) begin
            failures++;
            $display("FAIL done_pulse_width: got done=%0b result=%0d expected done=0 result=10",
                     done, result);
        end
    endtask

    task automatic test_start_on_done();
        test_search("a6", 4'd6, 1'b0, 3'b000, 3*CYC, 32'h0000_084_6, 4'd6, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL start_on_done_ignored: got busy=%0b done=%0b expected busy=0 done=0",
                     busy, done);
        end
        test_search("restart", 4'd5, 1'b0, 3'b000, 4*CYC, 32'h0000_8465, 4'd5, 1'b0);
    endtask

    task automatic test_abort();
        logic saw_done;
        test_search("pre_abort", 4'd10, 1'b0, 3'b000, 3*CYC, 32'h0000_08CA, 4'd10, 1'b0);
        step();
        a_val = 4'd9;
        start = 1'b1;
        step();
        // start pulsed again while busy must not restart the search.
        step();
        start = 1'b0;
        for (int i = 0; i < 8 && probe !== 4'd12; i++) step();
        checks++;
        if (probe !== 4'd12 || busy !== 1'b1) begin
            failures++;
            $display("FAIL start_while_busy: got probe=%0d busy=%0b expected probe=12 busy=1",
                     probe, busy);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || probe !== 4'd0 || done !== 1'b0 || result !== 4'd10) begin
            failures++;
            $display("FAIL abort_search: got busy=%0b probe=%0d done=%0b result=%0d expected 0 0 0 10",
                     busy, probe, done, result);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            saw_done = saw_done | done;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_done: got done after abort, expected none");
        end
        // An abort in IDLE has no effect, and start together with abort is ignored.
        abort = 1'b1;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || result !== 4'd10) begin
            failures++;
            $display("FAIL start_with_abort_ignored: got busy=%0b result=%0d expected busy=0 result=10",
                     busy, result);
        end
    endtask

    task automatic test_rst_mid_search();
        a_val = 4'd9;
        force_en = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (probe !== 4'd0 || busy !== 1'b0 || result !== 4'd0 || done !== 1'b0) begin
            failures++;
            $display("FAIL rst_async: got probe=%0d busy=%0b result=%0d done=%0b expected all zero",
                     probe, busy, result, done);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        test_search("after_rst", 4'd9, 1'b0, 3'b000, 4*CYC, 32'h0000_8CA9, 4'd9, 1'b0);
    endtask

    initial begin
        test_reset();
        test_search("a10", 4'd10, 1'b0, 3'b000, 3*CYC, 32'h0000_08CA, 4'd10, 1'b0);
        test_done_pulse();
        test_search("a0", 4'd0, 1'b0, 3'b000, 4*CYC, 32'h0000_8421, 4'd0, 1'b0);
        test_search("a15", 4'd15, 1'b0, 3'b000, 4*CYC, 32'h0000_8CEF, 4'd15, 1'b0);
        test_search("a1", 4'd1, 1'b0, 3'b000, 4*CYC, 32'h0000_8421, 4'd1, 1'b0);
        test_search("bad_flags", 4'd0, 1'b1, 3'b110, 1*CYC, 32'h0000_0008, 4'd8, 1'b1);
        test_search("greater_tied", 4'd0, 1'b1, 3'b100, 4*CYC, 32'h0000_8CEF, 4'd15, 1'b1);
        test_search("err_cleared", 4'd12, 1'b0, 3'b000, 2*CYC, 32'h0000_008C, 4'd12, 1'b0);
        test_start_on_done();
        test_abort();
        test_rst_mid_search();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
